// File: rtl/ssd_pkg.sv
// Shared display-code and segment constants for the seven-segment scan driver
// and the lock controller that produces the display word.
package ssd_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 4;

  typedef logic [CODE_W-1:0] ssd_code_t;
  typedef logic [SEG_W-1:0]  seg_t;

  // Display word as produced by the lock controller; d3 is the leftmost digit.
  typedef struct packed {
    ssd_code_t d3;
    ssd_code_t d2;
    ssd_code_t d1;
    ssd_code_t d0;
  } ssd_word_t;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } scan_state_e;

  localparam ssd_code_t CODE_0     = 5'h00;
  localparam ssd_code_t CODE_1     = 5'h01;
  localparam ssd_code_t CODE_2     = 5'h02;
  localparam ssd_code_t CODE_3     = 5'h03;
  localparam ssd_code_t CODE_4     = 5'h04;
  localparam ssd_code_t CODE_5     = 5'h05;
  localparam ssd_code_t CODE_6     = 5'h06;
  localparam ssd_code_t CODE_7     = 5'h07;
  localparam ssd_code_t CODE_8     = 5'h08;
  localparam ssd_code_t CODE_9     = 5'h09;
  localparam ssd_code_t CODE_A     = 5'h0A;
  localparam ssd_code_t CODE_B     = 5'h0B;
  localparam ssd_code_t CODE_C     = 5'h0C;
  localparam ssd_code_t CODE_D     = 5'h0D;
  localparam ssd_code_t CODE_E     = 5'h0E;
  localparam ssd_code_t CODE_F     = 5'h0F;
  localparam ssd_code_t CODE_BLANK = 5'h10;
  localparam ssd_code_t CODE_L     = 5'h11;
  localparam ssd_code_t CODE_LC_D  = 5'h12;
  localparam ssd_code_t CODE_P     = 5'h13;
  localparam ssd_code_t CODE_LC_N  = 5'h14;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Select one digit code out of the display word.
  function automatic ssd_code_t code_at(input ssd_word_t w, input logic [1:0] idx);
    ssd_code_t c;
    case (idx)
      2'd3:    c = w.d3;
      2'd2:    c = w.d2;
      2'd1:    c = w.d1;
      default: c = w.d0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ssd_decode.sv
// Combinational 5-bit display code to active-low {g,f,e,d,c,b,a} segment decode.
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (code)
      CODE_0:     seg_c = 7'b1000000;
      CODE_1:     seg_c = 7'b1111001;
      CODE_2:     seg_c = 7'b0100100;
      CODE_3:     seg_c = 7'b0110000;
      CODE_4:     seg_c = 7'b0011001;
      CODE_5:     seg_c = 7'b0010010;
      CODE_6:     seg_c = 7'b0000010;
      CODE_7:     seg_c = 7'b1111000;
      CODE_8:     seg_c = 7'b0000000;
      CODE_9:     seg_c = 7'b0010000;
      CODE_A:     seg_c = 7'b0001000;
      CODE_B:     seg_c = 7'b0000011;
      CODE_C:     seg_c = 7'b1000110;
      CODE_D:     seg_c = 7'b0100001;
      CODE_E:     seg_c = 7'b0000110;
      CODE_F:     seg_c = 7'b0001110;
      CODE_BLANK: seg_c = SEG_BLANK;
      CODE_L:     seg_c = 7'b1000111;
      CODE_LC_D:  seg_c = 7'b0100001;
      CODE_P:     seg_c = 7'b0001100;
      CODE_LC_N:  seg_c = 7'b0101011;
      default:    seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit time-multiplexed seven-segment scan driver with per-frame capture
// and anti-ghosting gaps. Optional blinking is enabled by defining SSD_BLINK_EN.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SSD_BLINK_EN
  input  logic        blink,
`endif
  input  logic [19:0] ssd_code,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CNT_W    = $clog2(REFRESH_DIV);
  localparam int unsigned GAP_LAST = BLANK_CYCLES - 1;
  localparam int unsigned ON_LAST  = REFRESH_DIV - BLANK_CYCLES - 1;

  if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV ||
      BLINK_FRAMES < 1) begin : g_bad_params
    $error("ssd_scan_driver: illegal REFRESH_DIV/BLANK_CYCLES/BLINK_FRAMES");
  end

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ssd_word_t        snap_q, snap_d;
  logic             capture_c;
  logic             dark_d;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  ssd_code_t        code_sel_c;
  logic [6:0]       seg_dec_c;

  assign dp = 1'b1;

  // Scan sequencing: gap then on-time per digit, snapshot taken entering digit 3.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    snap_d    = snap_q;
    capture_c = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          state_d = ST_ON;
          cnt_d   = '0;
          if (idx_q == 2'd3) begin
            capture_c = 1'b1;
            snap_d    = ssd_word_t'(ssd_code);
          end
        end
      end
      ST_ON: begin
        if (cnt_q == CNT_W'(ON_LAST)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          idx_d   = idx_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SSD_BLINK_EN
  localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);

  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               dark_q;

  // fcnt counts frames already shown in the current phase, including this one.
  always_comb begin
    fcnt_d = fcnt_q;
    dark_d = dark_q;
    if (capture_c) begin
      if (!blink) begin
        fcnt_d = '0;
        dark_d = 1'b0;
      end else if (fcnt_q == FRAME_W'(BLINK_FRAMES)) begin
        fcnt_d = FRAME_W'(1);
        dark_d = ~dark_q;
      end else begin
        fcnt_d = fcnt_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      dark_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      dark_q <= dark_d;
    end
  end
`else
  assign dark_d = 1'b0;
`endif

  assign code_sel_c = code_at(snap_d, idx_d);

  ssd_decode u_decode (
    .code  (code_sel_c),
    .seg_c (seg_dec_c)
  );

  // Outputs follow next-state so they switch on the same edge as the FSM.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    if (state_d == ST_ON && !dark_d) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_dec_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_GAP;
      idx_q      <= 2'd3;
      cnt_q      <= '0;
      snap_q     <= ssd_word_t'({DIGITS{CODE_BLANK}});
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      an         <= an_d;
      seg        <= seg_d;
      frame_tick <= capture_c;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: vector table, corner sequences and
// randomized codes against a time-position reference model.
module tb_ssd_scan_driver;

  localparam int unsigned RD     = 8;
  localparam int unsigned BC     = 2;
  localparam int unsigned BF     = 2;
  localparam int          SLOT   = RD;
  localparam int          ON_CYC = RD - BC;
  localparam int          FRAME  = 4 * RD;
  localparam logic [19:0] BLANK4 = 20'h84210;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] ssd_code;
  logic        blink_v;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SSD_BLINK_EN
    .blink      (blink_v),
`endif
    .ssd_code   (ssd_code),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int total = 0;
  int bad = 0;

  // Reference model state: edges since reset release, captured word, blink phase.
  int          t;
  logic [19:0] snap_m;
  logic        dark_m;
  int          run_m;
  logic        exp_on;
  int          exp_dig;
  logic        last_cap;

  logic [6:0] glyph_tbl [0:20] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h47, 7'h21, 7'h0C, 7'h2B
  };

  function automatic logic [6:0] glyph(input logic [4:0] c);
    if (int'(c) <= 20) return glyph_tbl[int'(c)];
    return 7'h3F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    snap_m = BLANK4;
    dark_m = 1'b0;
    run_m  = 0;
  endtask

  // One clock: advance the model by position in the frame, then compare all outputs.
  task automatic step();
    logic [19:0] pre;
    logic        bpre;
    int          u;
    logic [3:0]  ean;
    logic [6:0]  eseg;
    pre  = ssd_code;
    bpre = blink_v;
    @(posedge clk);
    #1;
    t++;
    u = t - int'(BC);
    last_cap = (u >= 0) && (u % FRAME == 0);
    if (last_cap) begin
      snap_m = pre;
`ifdef SSD_BLINK_EN
      if (bpre) begin
        run_m++;
        dark_m = (((run_m - 1) / int'(BF)) % 2) == 1;
      end else begin
        run_m  = 0;
        dark_m = 1'b0;
      end
`else
      if (bpre) run_m = 0;
`endif
    end
    exp_on  = (u >= 0) && ((u % SLOT) < ON_CYC) && !dark_m;
    exp_dig = (u >= 0) ? 3 - ((u / SLOT) % 4) : 3;
    ean  = exp_on ? 4'(~(4'b0001 << exp_dig)) : 4'hF;
    eseg = exp_on ? glyph(snap_m[exp_dig*5 +: 5]) : 7'h7F;
    check("an", 32'(an), 32'(ean));
    check("seg", 32'(seg), 32'(eseg));
    check("frame_tick", 32'(frame_tick), 32'(last_cap));
    check("dp", 32'(dp), 32'(1'b1));
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at t=%0d", name, t);
  endtask

  task automatic wait_capture();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_cap && n < FRAME + 4);
    if (!last_cap) timeout("wait_capture");
  endtask

  // Check every ON cycle up to (and stopping at) the next capture against a fixed glyph set.
  task automatic check_until_capture(input logic [27:0] segs, input string name);
    int n = 0;
    do begin
      step();
      n++;
      if (!last_cap && exp_on) check(name, 32'(seg), 32'(segs[exp_dig*7 +: 7]));
    end while (!last_cap && n < FRAME + 4);
    if (!last_cap) timeout(name);
  endtask

  task automatic wait_an(input logic [3:0] target, input int mid);
    int n = 0;
    while (!(an == target && (t - int'(BC)) % SLOT == mid) && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (n >= 2 * FRAME) timeout("wait_an");
  endtask

  typedef struct {
    logic [19:0] code;
    logic [27:0] segs;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lit;
    logic vis_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    vecs[0] = '{{5'h0C, 5'h11, 5'h05, 5'h12}, {7'h46, 7'h47, 7'h12, 7'h21}};
    vecs[1] = '{{5'h00, 5'h13, 5'h0E, 5'h14}, {7'h40, 7'h0C, 7'h06, 7'h2B}};
    vecs[2] = '{{5'h1F, 5'h10, 5'h15, 5'h10}, {7'h3F, 7'h7F, 7'h3F, 7'h7F}};
    vecs[3] = '{{5'h01, 5'h02, 5'h03, 5'h04}, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[4] = '{{5'h06, 5'h07, 5'h08, 5'h09}, {7'h02, 7'h78, 7'h00, 7'h10}};
    vecs[5] = '{{5'h0A, 5'h0B, 5'h0E, 5'h0F}, {7'h08, 7'h03, 7'h06, 7'h0E}};
    vecs[6] = '{{5'h0D, 5'h16, 5'h1E, 5'h11}, {7'h21, 7'h3F, 7'h3F, 7'h47}};

    ssd_code = vecs[0].code;
    blink_v  = 1'b0;
    last_cap = 1'b0;
    model_reset();

    // Reset state while held.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    model_reset();
    step();
    check("tick_after1", 32'(frame_tick), 32'h0);
    step();
    check("tick_after2", 32'(frame_tick), 32'h1);
    check("first_an", 32'(an), 32'h7);

    // Vector table: one frame per word, each slot against its listed glyph.
    for (int i = 0; i < 7; i++) begin
      ssd_code = vecs[i].code;
      wait_capture();
      check("vec_first_seg", 32'(seg), 32'(vecs[i].segs[27:21]));
      check_until_capture(vecs[i].segs, "vec_seg");
    end

    // Tearing: change the word mid-frame; old glyphs stay until the next capture.
    ssd_code = vecs[0].code;
    wait_capture();
    wait_an(4'b1011, 1);
    ssd_code = vecs[1].code;
    check_until_capture(vecs[0].segs, "tear_old");
    check("tear_new_first", 32'(seg), 32'h40);
    check_until_capture(vecs[1].segs, "tear_new");

    // Asynchronous reset in the middle of the an=1101 slot.
    wait_an(4'b1101, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'h0000000F);
    check("arst_seg", 32'(seg), 32'h0000007F);
    check("arst_tick", 32'(frame_tick), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    step();
    check("arst_tick2", 32'(frame_tick), 32'h1);
    check("arst_an2", 32'(an), 32'h7);

    // Randomized words, changed at arbitrary cycles.
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 11) == 0) ssd_code = 20'($urandom);
      step();
    end

`ifdef SSD_BLINK_EN
    // Blink: two visible then two dark frames, steady again after blink drops.
    ssd_code = vecs[3].code;
    wait_capture();
    blink_v = 1'b1;
    wait_capture();
    for (int f = 0; f < 6; f++) begin
      lit = (an != 4'hF) ? 1 : 0;
      begin
        int n = 0;
        do begin
          step();
          n++;
          if (!last_cap && an != 4'hF) lit++;
        end while (!last_cap && n < FRAME + 4);
      end
      check("blink_visible", 32'(lit != 0), 32'(vis_pat[f]));
    end
    blink_v = 1'b0;
    wait_capture();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ($urandom_range(0, 3) == 0) blink_v = 1'($urandom);
      step();
    end
    blink_v = 1'b0;
    wait_capture();
    check_until_capture(vecs[3].segs, "blink_off");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
